// File: rtl/ipv6_header_parser_pkg.sv
// IPv6 fixed-header layout shared by the parser and its consumers.
package package_ipv6;

  localparam int IPV6_HDR_WORDS = 10;

  // Field order follows the wire order; Version sits in the MSBs (header bit 0).
  typedef struct packed {
    logic [3:0]   Version;
    logic [7:0]   TrafficClass;
    logic [19:0]  FlowLabel;
    logic [15:0]  PayloadLength;
    logic [7:0]   NextHeader;
    logic [7:0]   HopLimit;
    logic [127:0] SourceAddress;
    logic [127:0] DestinationAddress;
  } t_ipv6_header;

endpackage

// File: rtl/ipv6_header_parser.sv
// Splits an IPv6 word stream into a registered header and a pass-through payload; IPV6_VERSION_CHECK_EN drops non-v6 packets.
// Header valid 1 cycle after word 9, held (input stalled) until accepted; payload is combinational with ready passed upstream.
module ipv6_header_parser
  import package_ipv6::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output t_ipv6_header  hdr,
  output logic          hdr_valid,
  input  logic          hdr_ready,
  output logic [DW-1:0] pld_data,
  output logic          pld_valid,
  output logic          pld_last,
  input  logic          pld_ready,
  output logic          err
);

  typedef enum logic [1:0] {S_HDR, S_HOLD, S_PLD, S_DROP} t_state;

  t_state      state, state_nxt;
  logic [3:0]  wcnt;
  logic [14:0] pcnt;
  logic [14:0] pl_words;
  logic [8:0]  wbit;
  logic        skip_pld;
  logic        err_nxt;
  logic        xfer;
  logic        ver_bad;

  assign xfer     = in_valid & in_ready;
  assign pld_data = in_data;
  assign pl_words = 15'(({1'b0, hdr.PayloadLength} + 17'd3) >> 2);
  assign wbit     = 9'((IPV6_HDR_WORDS - 1 - int'(wcnt)) * DW);

`ifdef IPV6_VERSION_CHECK_EN
  assign ver_bad = (wcnt == 4'd0) && (in_data[DW-1 -: 4] != 4'd6);
`else
  assign ver_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pld_valid = 1'b0;
    pld_last  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (ver_bad) begin
            err_nxt   = 1'b1;
            state_nxt = in_last ? S_HDR : S_DROP;
          end else if (wcnt == 4'(IPV6_HDR_WORDS - 1)) begin
            state_nxt = S_HOLD;
            // Packet ends with the header although a payload was announced.
            err_nxt   = in_last && (hdr.PayloadLength != 16'd0);
          end else if (in_last) begin
            err_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hdr_valid && hdr_ready)
          state_nxt = (hdr.PayloadLength != 16'd0 && !skip_pld) ? S_PLD : S_HDR;
      end
      S_PLD: begin
        in_ready  = pld_ready;
        pld_valid = in_valid;
        pld_last  = in_last || (pcnt == 15'd1);
        if (in_valid && pld_ready) begin
          if (pcnt == 15'd1) begin
            err_nxt   = !in_last;
            state_nxt = in_last ? S_HDR : S_DROP;
          end else if (in_last) begin
            err_nxt   = 1'b1;
            state_nxt = S_HDR;
          end
        end
      end
      S_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last)
          state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HDR;
      wcnt      <= 4'd0;
      pcnt      <= 15'd0;
      skip_pld  <= 1'b0;
      hdr       <= '0;
      hdr_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      case (state)
        S_HDR: begin
          if (xfer) begin
            if (ver_bad) begin
              wcnt <= 4'd0;
            end else begin
              hdr[wbit +: DW] <= in_data;
              if (wcnt == 4'(IPV6_HDR_WORDS - 1)) begin
                wcnt      <= 4'd0;
                hdr_valid <= 1'b1;
                skip_pld  <= in_last;
              end else if (in_last) begin
                wcnt <= 4'd0;
              end else begin
                wcnt <= wcnt + 4'd1;
              end
            end
          end
        end
        S_HOLD: begin
          if (hdr_valid && hdr_ready) begin
            hdr_valid <= 1'b0;
            pcnt      <= pl_words;
          end
        end
        S_PLD: begin
          if (xfer)
            pcnt <= pcnt - 15'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv6_header_parser.sv
// Scoreboard bench for ipv6_header_parser: directed packets, expected headers/payload queued, monitor compares.
module tb_ipv6_header_parser;
  import package_ipv6::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  t_ipv6_header hdr;
  logic         hdr_valid;
  logic         hdr_ready = 1'b1;
  logic [31:0]  pld_data;
  logic         pld_valid;
  logic         pld_last;
  logic         pld_ready = 1'b1;
  logic         err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;

  t_ipv6_header exp_hdr[$];
  logic [32:0]  exp_pld[$];

  ipv6_header_parser #(.DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .hdr(hdr), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_last(pld_last), .pld_ready(pld_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic t_ipv6_header mk(input logic [15:0] pl, input logic [7:0] tag);
    t_ipv6_header h;
    h.Version            = 4'd6;
    h.TrafficClass       = tag;
    h.FlowLabel          = 20'hABCDE;
    h.PayloadLength      = pl;
    h.NextHeader         = 8'h11;
    h.HopLimit           = 8'h40;
    h.SourceAddress      = {32'h2001_0db8, 88'h0, tag};
    h.DestinationAddress = {32'hfe80_0000, 88'h1, tag};
    return h;
  endfunction

  function automatic logic [31:0] word(input t_ipv6_header h, input int k);
    logic [319:0] v;
    v = h;
    return v[319 - 32*k -: 32];
  endfunction

  // Presents one word and returns 1 ns after the clock edge that transferred it.
  task automatic send(input logic [31:0] d, input logic l);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: in_ready stuck 0, required 1 within 200 cycles");
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_hdr(input t_ipv6_header h, input int nwords, input bit last_at_end);
    for (int k = 0; k < nwords; k++)
      send(word(h, k), last_at_end && (k == nwords - 1));
  endtask

  task automatic endchk(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_err_count"}, 320'(err_seen), 320'(err_exp));
    chk({tag, "_hdr_q_empty"}, 320'(exp_hdr.size()), 320'(0));
    chk({tag, "_pld_q_empty"}, 320'(exp_pld.size()), 320'(0));
  endtask

  // Monitor: compares every accepted header / payload word against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid && hdr_ready) begin
        if (exp_hdr.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr_unexpected: got hdr_valid=1 with %0h, required no header", hdr);
        end else begin
          chk("hdr", 320'(hdr), 320'(exp_hdr.pop_front()));
        end
      end
      if (pld_valid && pld_ready) begin
        if (exp_pld.size() == 0) begin
          checks++; errors++;
          $display("FAIL pld_unexpected: got last=%0b data=%0h, required no payload", pld_last, pld_data);
        end else begin
          chk("pld_last_data", 320'({pld_last, pld_data}), 320'(exp_pld.pop_front()));
        end
      end
      if (err) err_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    t_ipv6_header h;
    t_ipv6_header h2;

    // Reset state
    #12;
    chk("rst_hdr_valid", 320'(hdr_valid), 320'(1'b0));
    chk("rst_err", 320'(err), 320'(1'b0));
    chk("rst_pld_valid", 320'(pld_valid), 320'(1'b0));
    chk("rst_hdr", 320'(hdr), 320'(0));
    chk("rst_in_ready", 320'(in_ready), 320'(1'b1));
    @(posedge clk); #1;
    rst = 1'b0;

    // PL=8 -> 2 words, then back-to-back PL=5 -> 2 words
    h = mk(16'd8, 8'h01);
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b0, 32'hA0A0_0001});
    exp_pld.push_back({1'b1, 32'hA0A0_0002});
    send_hdr(h, 10, 1'b0);
    chk("s1_hdr_valid_latency", 320'(hdr_valid), 320'(1'b1));
    chk("s1_in_ready_hold", 320'(in_ready), 320'(1'b0));
    chk("s1_payload_length", 320'(hdr.PayloadLength), 320'(16'd8));
    chk("s1_next_header", 320'(hdr.NextHeader), 320'(8'h11));
    send(32'hA0A0_0001, 1'b0);
    send(32'hA0A0_0002, 1'b1);
    h = mk(16'd5, 8'h02);
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b0, 32'hB0B0_0001});
    exp_pld.push_back({1'b1, 32'hB0B0_0002});
    send_hdr(h, 10, 1'b0);
    send(32'hB0B0_0001, 1'b0);
    send(32'hB0B0_0002, 1'b1);
    endchk("s1_s2");

    // Truncated header: last on word 4, then a normal PL=0 packet
    h = mk(16'd8, 8'h03);
    err_exp++;
    send_hdr(h, 5, 1'b1);
    h = mk(16'd0, 8'h04);
    exp_hdr.push_back(h);
    send_hdr(h, 10, 1'b1);
    endchk("s3");

    // Header stall for 5 cycles
    h = mk(16'd4, 8'h05);
    hdr_ready = 1'b0;
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b1, 32'hC0C0_0001});
    send_hdr(h, 10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s4_stall_in_ready", 320'(in_ready), 320'(1'b0));
      chk("s4_stall_hdr", 320'(hdr), 320'(h));
      chk("s4_stall_hdr_valid", 320'(hdr_valid), 320'(1'b1));
    end
    @(posedge clk); #1;
    hdr_ready = 1'b1;
    send(32'hC0C0_0001, 1'b1);
    endchk("s4");

    // PL=4 but 3 payload words: first forwarded with pld_last, rest dropped
    h = mk(16'd4, 8'h06);
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b1, 32'hD0D0_0001});
    err_exp++;
    send_hdr(h, 10, 1'b0);
    send(32'hD0D0_0001, 1'b0);
    send(32'hD0D0_0002, 1'b0);
    send(32'hD0D0_0003, 1'b1);
    h2 = mk(16'd0, 8'h07);
    exp_hdr.push_back(h2);
    send_hdr(h2, 10, 1'b1);
    endchk("s5");

    // Reset mid-payload
    h = mk(16'd12, 8'h08);
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b0, 32'hE0E0_0001});
    send_hdr(h, 10, 1'b0);
    send(32'hE0E0_0001, 1'b0);
    in_data  = 32'hE0E0_0002;
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    chk("s6_rst_hdr_valid", 320'(hdr_valid), 320'(1'b0));
    chk("s6_rst_err", 320'(err), 320'(1'b0));
    chk("s6_rst_pld_valid", 320'(pld_valid), 320'(1'b0));
    chk("s6_rst_hdr", 320'(hdr), 320'(0));
    chk("s6_rst_in_ready", 320'(in_ready), 320'(1'b1));
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    h = mk(16'd4, 8'h09);
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b1, 32'hF0F0_0001});
    send_hdr(h, 10, 1'b0);
    send(32'hF0F0_0001, 1'b1);
    endchk("s6");

    // Last on word 9 with PL!=0: header presented, error, no payload phase
    h = mk(16'd8, 8'h0A);
    exp_hdr.push_back(h);
    err_exp++;
    send_hdr(h, 10, 1'b1);
    h = mk(16'd4, 8'h0B);
    exp_hdr.push_back(h);
    exp_pld.push_back({1'b1, 32'h1234_5678});
    send_hdr(h, 10, 1'b0);
    send(32'h1234_5678, 1'b1);
    endchk("s7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipv6_header_parser.md
IPV6_HEADER_PARSER -- requirements
Module: ipv6_header_parser

Interface
REQ-001 SHALL have parameter DW, default 32, meaning input/payload word width in bits; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_data  input  DW  packet stream word, big-endian, first word = header bits [0:31].
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_last  input  1  final word of packet.
REQ-007 SHALL have port in_ready  output  1  stream accept; transfer = in_valid & in_ready.
REQ-008 SHALL have port hdr  output  t_ipv6_header (320)  captured header.
REQ-009 SHALL have port hdr_valid  output  1  hdr valid.
REQ-010 SHALL have port hdr_ready  input  1  downstream header accept.
REQ-011 SHALL have port pld_data  output  DW  payload word.
REQ-012 SHALL have port pld_valid  output  1  payload valid.
REQ-013 SHALL have port pld_last  output  1  final payload word.
REQ-014 SHALL have port pld_ready  input  1  payload accept.
REQ-015 SHALL have port err  output  1  single-cycle error pulse.

Function
REQ-016 SHALL implement FSM states S_HDR, S_HOLD, S_PLD, S_DROP.
REQ-017 In S_HDR: in_ready=1; word k (0..9) stored in header bits [32k:32k+31]; 4-bit word counter.
REQ-018 On word 9 transfer: go to S_HOLD; hdr_valid=1 next cycle; hdr registered, stable until accepted.
REQ-019 In S_HOLD: in_ready=0; on hdr_valid & hdr_ready: hdr_valid=0; go to S_PLD if PayloadLength!=0, else S_HDR.
REQ-020 Payload word count = (PayloadLength+3)>>2, computed 17-bit, stored 15-bit down-counter.
REQ-021 In S_PLD: pld_data=in_data, pld_valid=in_valid, in_ready=pld_ready (combinational); counter decrements per transfer.
REQ-022 pld_last = in_last | (counter==1).
REQ-023 Counter reaching 0 with in_last: go to S_HDR.
REQ-024 Counter reaching 0 without in_last: pulse err; go to S_DROP.
REQ-025 in_last in S_PLD with counter>1: pulse err; go to S_HDR.
REQ-026 In S_DROP: in_ready=1; discard words; in_last transfer returns to S_HDR.
REQ-027 in_last on header word 0..8: pulse err; no hdr_valid; counter cleared; stay in S_HDR.
REQ-028 in_last on word 9 with PayloadLength!=0: hdr still presented; err pulse; return to S_HDR after acceptance (no S_PLD).
REQ-029 pld_valid=0 in all states except S_PLD.
REQ-030 Back-to-back packets: no idle cycle required between a last transfer and next header word 0.

Reset
REQ-031 rst asserted SHALL force S_HDR, counters 0, hdr_valid=0, err=0, hdr=0 immediately (asynchronous).
REQ-032 Reset mid-packet SHALL discard partial state; first word after deassertion is treated as header word 0.

Configuration
REQ-033 With IPV6_VERSION_CHECK_EN defined: on word 0, Version!=6 -> err pulse; go to S_DROP (or S_HDR if in_last); no hdr_valid.
REQ-034 Without IPV6_VERSION_CHECK_EN: Version not checked; all headers forwarded.

Structure
REQ-035 t_ipv6_header (packed, ascending fields Version..DestinationAddress, 320 bits) and constant IPV6_HDR_WORDS=10 SHALL reside in package_ipv6.
REQ-036 FSM state enum SHALL be local to the module; no sub-module required.

Verification
REQ-037 Header PayloadLength=8, 2 payload words, last on word 11, ready always 1 -> hdr_valid 1 cycle after word 9; pld_last on 2nd payload word; err=0.
REQ-038 PayloadLength=5 -> exactly 2 payload words forwarded; pld_last on 2nd.
REQ-039 in_last on header word 4 -> err pulse 1 cycle; hdr_valid never 1; next packet parsed normally.
REQ-040 hdr_ready held 0 for 5 cycles -> in_ready=0, hdr stable throughout; payload flows after acceptance.
REQ-041 PayloadLength=4 but 3 payload words, last on 3rd -> 1st forwarded; err pulse; remaining words dropped through last.
REQ-042 rst asserted mid-payload -> outputs at reset values same cycle; following packet parsed from word 0.
